// File: rtl/pnu_shreg_pkg.sv
// Shared definitions for the pnu_shreg universal shift register family:
// mode encodings, auto-shift FSM states and a shift/rotate classifier.
// Pure package; no latency and no backpressure.
package pnu_shreg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_CLR  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True for the four modes the auto-shift controller may run.
  function automatic logic is_shift_mode(input logic [2:0] m);
    return (m == MODE_SHL) || (m == MODE_SHR) ||
           (m == MODE_ROL) || (m == MODE_ROR);
  endfunction

endpackage

// File: rtl/pnu_shreg_auto_if.sv
// Control/data bundle between a driver and pnu_shreg_auto.
// No latency of its own; purely wiring.
// No backpressure: Ce is the only stall mechanism.
interface pnu_shreg_auto_if #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) ();
  logic             Ce;
  logic [2:0]       Mode;
  logic [WIDTH-1:0] Din;
  logic             Sin;
  logic             Start;
  logic [CW-1:0]    Cnt;
  logic [WIDTH-1:0] Dout;
  logic             Sout;
  logic             Busy;
  logic             Done;

  modport master (
    output Ce, Mode, Din, Sin, Start, Cnt,
    input  Dout, Sout, Busy, Done
  );

  modport slave (
    input  Ce, Mode, Din, Sin, Start, Cnt,
    output Dout, Sout, Busy, Done
  );
endinterface

// File: rtl/pnu_shreg_core.sv
// WIDTH-bit universal register: hold/load/shift/rotate/clear plus serial-out flop.
// Latency: result visible one edge after an enabled cycle.
// No backpressure; en=0 freezes all state.
module pnu_shreg_core
  import pnu_shreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
  output logic [WIDTH-1:0] dout,
  output logic             sout
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_nxt;
  logic             sout_q;
  logic             sout_nxt;

  // Next-state mux: Sout only moves on shift/rotate, taking the bit pushed out.
  always_comb begin
    data_nxt = data_q;
    sout_nxt = sout_q;
    case (mode)
      MODE_LOAD: data_nxt = din;
      MODE_SHL: begin
        data_nxt = {data_q[WIDTH-2:0], sin};
        sout_nxt = data_q[WIDTH-1];
      end
      MODE_SHR: begin
        data_nxt = {sin, data_q[WIDTH-1:1]};
        sout_nxt = data_q[0];
      end
      MODE_ROL: begin
        data_nxt = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
        sout_nxt = data_q[WIDTH-1];
      end
      MODE_ROR: begin
        data_nxt = {data_q[0], data_q[WIDTH-1:1]};
        sout_nxt = data_q[0];
      end
      MODE_CLR: data_nxt = '0;
      default:  ;
    endcase
  end

  // Register update, gated by the effective enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      sout_q <= 1'b0;
    end else if (en) begin
      data_q <= data_nxt;
      sout_q <= sout_nxt;
    end
  end

  assign dout = data_q;
  assign sout = sout_q;

endmodule

// File: rtl/pnu_shreg_auto.sv
// Universal shift register with optional auto-shift controller (PNU_SHREG_AUTO_EN).
// Latency: direct modes 1 edge; auto-shift of N takes N+1 edges to Done (+1 per Ce=0 stall).
// No backpressure; Ce stalls everything except the one-cycle Done state.
module pnu_shreg_auto
  import pnu_shreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  pnu_shreg_auto_if.slave   bus
);

  logic [2:0] eff_mode;

`ifdef PNU_SHREG_AUTO_EN
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    op_q;
  logic          busy_q;
  logic          done_q;
  logic          start_hit;
  logic [CW-1:0] cnt_clamped;

  assign start_hit   = (state_q == ST_IDLE) && bus.Ce && bus.Start &&
                       is_shift_mode(bus.Mode);
  assign cnt_clamped = (bus.Cnt > CW'(WIDTH)) ? CW'(WIDTH) : bus.Cnt;

  // Effective mode: latched op while running, hold on the Start cycle and in DONE.
  always_comb begin
    eff_mode = bus.Mode;
    if (state_q == ST_RUN)
      eff_mode = op_q;
    else if (start_hit || (state_q == ST_DONE))
      eff_mode = MODE_HOLD;
  end

  // Auto-shift FSM with registered Busy/Done.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MODE_HOLD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_hit) begin
            op_q <= bus.Mode;
            cnt_q <= cnt_clamped;
            if (cnt_clamped == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (bus.Ce) begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Busy = busy_q;
  assign bus.Done = done_q;
`else
  logic unused_auto;

  assign unused_auto = ^{bus.Start, bus.Cnt};

  // Without the controller the Mode input drives the core directly.
  always_comb begin
    eff_mode = bus.Mode;
  end

  assign bus.Busy = 1'b0;
  assign bus.Done = 1'b0;
`endif

  pnu_shreg_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk   (CLK),
    .rst_n (RST),
    .en    (bus.Ce),
    .mode  (eff_mode),
    .din   (bus.Din),
    .sin   (bus.Sin),
    .dout  (bus.Dout),
    .sout  (bus.Sout)
  );

endmodule

// File: tb/tb_pnu_shreg_auto.sv
// Directed bench for pnu_shreg_auto (WIDTH=8), hand-computed expectations.
// Auto-shift scenarios are exercised when PNU_SHREG_AUTO_EN is defined,
// otherwise the bench checks that Start is inert and Busy/Done stay low.
module tb_pnu_shreg_auto;
  import pnu_shreg_pkg::*;

  localparam int WIDTH = 8;

  logic CLK;
  logic RST;
  int   n_checks;
  int   n_errors;

  pnu_shreg_auto_if #(.WIDTH(WIDTH)) bus ();

  pnu_shreg_auto #(.WIDTH(WIDTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic ce, input logic [2:0] mode, input logic sin,
                       input logic start, input logic [3:0] cnt);
    bus.Ce    = ce;
    bus.Mode  = mode;
    bus.Sin   = sin;
    bus.Start = start;
    bus.Cnt   = cnt;
  endtask

  task automatic load(input logic [7:0] v);
    bus.Din = v;
    drive(1'b1, MODE_LOAD, 1'b0, 1'b0, 4'd0);
    tick();
    drive(1'b1, MODE_HOLD, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic check_status(input string tag, input logic busy, input logic done);
    check({tag, ".busy"}, 32'(bus.Busy), 32'(busy));
    check({tag, ".done"}, 32'(bus.Done), 32'(done));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    RST = 1'b0;
    bus.Din = '0;
    drive(1'b0, MODE_HOLD, 1'b0, 1'b0, 4'd0);
    #12;
    check("rst.dout", 32'(bus.Dout), 32'h00);
    check("rst.sout", 32'(bus.Sout), 32'h0);
    check_status("rst", 1'b0, 1'b0);
    RST = 1'b1;
    tick();

    // Asynchronous reset in the middle of normal operation.
    load(8'h3C);
    check("pre_rst.dout", 32'(bus.Dout), 32'h3C);
    drive(1'b1, MODE_SHL, 1'b1, 1'b0, 4'd0);
    tick();
    #2 RST = 1'b0;
    #1;
    check("async_rst.dout", 32'(bus.Dout), 32'h00);
    check("async_rst.sout", 32'(bus.Sout), 32'h0);
    check_status("async_rst", 1'b0, 1'b0);
    RST = 1'b1;
    drive(1'b1, MODE_HOLD, 1'b0, 1'b0, 4'd0);
    tick();

    // LOAD then Ce=0 freeze.
    load(8'hA5);
    check("load.dout", 32'(bus.Dout), 32'hA5);
    drive(1'b0, MODE_SHL, 1'b1, 1'b0, 4'd0);
    tick();
    check("ce0.dout", 32'(bus.Dout), 32'hA5);

    // Direct rotate, shift and clear from 81.
    load(8'h81);
    drive(1'b1, MODE_ROL, 1'b0, 1'b0, 4'd0);
    tick();
    check("rol.dout", 32'(bus.Dout), 32'h03);
    check("rol.sout", 32'(bus.Sout), 32'h1);
    drive(1'b1, MODE_SHR, 1'b0, 1'b0, 4'd0);
    tick();
    check("shr.dout", 32'(bus.Dout), 32'h01);
    check("shr.sout", 32'(bus.Sout), 32'h1);
    drive(1'b1, MODE_CLR, 1'b0, 1'b0, 4'd0);
    tick();
    check("clr.dout", 32'(bus.Dout), 32'h00);
    check("clr.sout", 32'(bus.Sout), 32'h1);

`ifdef PNU_SHREG_AUTO_EN
    // Auto SHL x3 from 01; Mode changes during RUN must be ignored.
    load(8'h01);
    drive(1'b1, MODE_SHL, 1'b0, 1'b1, 4'd3);
    tick();
    check("ashl.start.dout", 32'(bus.Dout), 32'h01);
    check_status("ashl.start", 1'b1, 1'b0);
    drive(1'b1, MODE_LOAD, 1'b0, 1'b0, 4'd0);
    tick();
    check("ashl.s1", 32'(bus.Dout), 32'h02);
    check_status("ashl.s1", 1'b1, 1'b0);
    tick();
    check("ashl.s2", 32'(bus.Dout), 32'h04);
    check_status("ashl.s2", 1'b1, 1'b0);
    tick();
    check("ashl.s3", 32'(bus.Dout), 32'h08);
    check_status("ashl.s3", 1'b0, 1'b1);
    drive(1'b1, MODE_HOLD, 1'b0, 1'b0, 4'd0);
    tick();
    check("ashl.after", 32'(bus.Dout), 32'h08);
    check_status("ashl.after", 1'b0, 1'b0);

    // Auto ROR x4 from F0 with one stall cycle.
    load(8'hF0);
    drive(1'b1, MODE_ROR, 1'b0, 1'b1, 4'd4);
    tick();
    drive(1'b1, MODE_HOLD, 1'b0, 1'b0, 4'd0);
    tick();
    check("aror.s1", 32'(bus.Dout), 32'h78);
    tick();
    check("aror.s2", 32'(bus.Dout), 32'h3C);
    bus.Ce = 1'b0;
    tick();
    check("aror.stall", 32'(bus.Dout), 32'h3C);
    check_status("aror.stall", 1'b1, 1'b0);
    bus.Ce = 1'b1;
    tick();
    check("aror.s3", 32'(bus.Dout), 32'h1E);
    check_status("aror.s3", 1'b1, 1'b0);
    tick();
    check("aror.s4", 32'(bus.Dout), 32'h0F);
    check("aror.sout", 32'(bus.Sout), 32'h0);
    check_status("aror.s4", 1'b0, 1'b1);
    tick();
    check_status("aror.after", 1'b0, 1'b0);

    // Cnt=0: Done next cycle, no shift; DONE cycle holds even with Mode=SHL.
    drive(1'b1, MODE_SHL, 1'b1, 1'b1, 4'd0);
    tick();
    check("cnt0.dout", 32'(bus.Dout), 32'h0F);
    check_status("cnt0", 1'b0, 1'b1);
    drive(1'b1, MODE_SHL, 1'b1, 1'b0, 4'd0);
    tick();
    check("cnt0.done_hold", 32'(bus.Dout), 32'h0F);
    check_status("cnt0.after", 1'b0, 1'b0);
    drive(1'b1, MODE_HOLD, 1'b0, 1'b0, 4'd0);

    // Cnt=15 clamps to 8 rotates.
    load(8'h01);
    drive(1'b1, MODE_ROL, 1'b0, 1'b1, 4'd15);
    tick();
    drive(1'b1, MODE_HOLD, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 7; i++) tick();
    check("clamp.s7", 32'(bus.Dout), 32'h80);
    check_status("clamp.s7", 1'b1, 1'b0);
    tick();
    check("clamp.s8", 32'(bus.Dout), 32'h01);
    check_status("clamp.s8", 1'b0, 1'b1);
    tick();
    check_status("clamp.after", 1'b0, 1'b0);

    // Start held through RUN and DONE is ignored.
    load(8'h01);
    drive(1'b1, MODE_SHL, 1'b1, 1'b1, 4'd2);
    tick();
    drive(1'b1, MODE_SHL, 1'b1, 1'b1, 4'd5);
    tick();
    check("srun.s1", 32'(bus.Dout), 32'h03);
    tick();
    check("srun.s2", 32'(bus.Dout), 32'h07);
    check_status("srun.s2", 1'b0, 1'b1);
    drive(1'b1, MODE_HOLD, 1'b0, 1'b0, 4'd0);
    tick();
    check("srun.after", 32'(bus.Dout), 32'h07);
    check_status("srun.after", 1'b0, 1'b0);

    // Reset during RUN aborts without Done.
    load(8'h01);
    drive(1'b1, MODE_SHL, 1'b0, 1'b1, 4'd3);
    tick();
    drive(1'b1, MODE_HOLD, 1'b0, 1'b0, 4'd0);
    tick();
    check("rrun.s1", 32'(bus.Dout), 32'h02);
    RST = 1'b0;
    #1;
    check("rrun.dout", 32'(bus.Dout), 32'h00);
    check_status("rrun.rst", 1'b0, 1'b0);
    #1 RST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_status("rrun.post", 1'b0, 1'b0);
    end
    check("rrun.post.dout", 32'(bus.Dout), 32'h00);
`else
    // Controller absent: Start is inert and the Mode executes directly.
    load(8'h01);
    drive(1'b1, MODE_SHL, 1'b0, 1'b1, 4'd3);
    tick();
    check("noauto.dout", 32'(bus.Dout), 32'h02);
    check_status("noauto.start", 1'b0, 1'b0);
    drive(1'b1, MODE_HOLD, 1'b0, 1'b1, 4'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_status("noauto.idle", 1'b0, 1'b0);
    end
    check("noauto.hold", 32'(bus.Dout), 32'h02);
    drive(1'b1, MODE_ROR, 1'b0, 1'b1, 4'd15);
    tick();
    check("noauto.ror", 32'(bus.Dout), 32'h01);
    check_status("noauto.ror", 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
